// File: rtl/wrf_pkg.sv
// rtl/wrf_pkg.sv - shared types, default sizes and helpers for the window register file
package wrf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SPILL = 2'd1,
      ST_FILL  = 2'd2
   } wrf_state_t;

   // Ceiling log2, clamped to 1 so a degenerate size still yields a legal vector width.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int x = value - 1; x > 0; x = x >> 1) begin
         result++;
      end
      return (result == 0) ? 1 : result;
   endfunction

   localparam int DATA_W_DEF = 16;
   localparam int NREG_DEF   = 4;
   localparam int STRIDE_DEF = 2;
   localparam int NWIN_DEF   = 4;
   localparam int SPW_DEF    = 8;

   localparam int NPHYS = NWIN_DEF * STRIDE_DEF;
   localparam int AW    = clog2(NREG_DEF);
   localparam int WW    = clog2(NWIN_DEF);

endpackage

// File: rtl/window_regfile_if.sv
// rtl/window_regfile_if.sv - register ports, window control and spill/fill streams of the window register file
interface window_regfile_if #(
   parameter int DATA_W = 16,
   parameter int AW     = 2,
   parameter int WW     = 2
);
   logic [AW-1:0]     rd_addr1;
   logic [AW-1:0]     rd_addr2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              save;
   logic              restore;
   logic              busy;
   logic [WW-1:0]     cwp;
   logic              fault;
   logic              spill_valid;
   logic              spill_ready;
   logic [DATA_W-1:0] spill_data;
   logic              fill_valid;
   logic              fill_ready;
   logic [DATA_W-1:0] fill_data;

   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, save, restore,
      output spill_ready, fill_valid, fill_data,
      input  rd_data1, rd_data2, busy, cwp, fault, spill_valid, spill_data, fill_ready
   );

   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, save, restore,
      input  spill_ready, fill_valid, fill_data,
      output rd_data1, rd_data2, busy, cwp, fault, spill_valid, spill_data, fill_ready
   );
endinterface

// File: rtl/wrf_addr_map.sv
// rtl/wrf_addr_map.sv - maps a visible register of a window onto the circular physical bank
module wrf_addr_map
   import wrf_pkg::*;
#(
   parameter int NREG   = 4,
   parameter int STRIDE = 2,
   parameter int NWIN   = 4,
   localparam int ADDR_W = clog2(NREG),
   localparam int WIN_W  = clog2(NWIN),
   localparam int PHYS_N = NWIN * STRIDE,
   localparam int IDX_W  = clog2(PHYS_N)
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIN_W-1:0]  win,
   output logic [IDX_W-1:0]  idx
);
   localparam int SUM_W = IDX_W + 1;

   // addr < NREG <= 2*STRIDE keeps the sum below 2*PHYS_N, so one conditional subtract wraps it.
   logic [SUM_W-1:0] sum;

   assign sum = SUM_W'(addr) + SUM_W'(win) * SUM_W'(STRIDE);
   assign idx = (sum >= SUM_W'(PHYS_N)) ? IDX_W'(sum - SUM_W'(PHYS_N)) : IDX_W'(sum);

endmodule

// File: rtl/window_regfile.sv
// rtl/window_regfile.sv - sliding-window register file with spill/fill of overflowing windows
module window_regfile
   import wrf_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREG   = 4,
   parameter int STRIDE = 2,
   parameter int NWIN   = 4,
   parameter int SPW    = 8
) (
   input logic             clk,
   input logic             rst_n,
   window_regfile_if.slave bus
);
   localparam int ADDR_W = clog2(NREG);
   localparam int WIN_W  = clog2(NWIN);
   localparam int PHYS_N = NWIN * STRIDE;
   localparam int IDX_W  = clog2(PHYS_N);

   logic [DATA_W-1:0] phys [PHYS_N];

   wrf_state_t        state, state_nx;
   logic [WIN_W-1:0]  cwp_q, cwp_nx;
   logic [WIN_W-1:0]  res_q, res_nx;
   logic [SPW-1:0]    spl_q, spl_nx;
   logic [ADDR_W-1:0] beat_q, beat_nx;
   logic              fault_q, fault_nx;
   logic              spill_valid, fill_ready;
   logic              fill_fire, last_beat;
   logic [WIN_W-1:0]  blk_win;
   logic [IDX_W-1:0]  rd1_idx, rd2_idx, wr_idx, blk_idx;

   // Spill drains the oldest resident window; fill refills the one just below cwp.
   assign blk_win   = (state == ST_FILL) ? cwp_q - WIN_W'(1) : cwp_q - res_q + WIN_W'(1);
   assign last_beat = (beat_q == ADDR_W'(STRIDE - 1));
   assign fill_fire = fill_ready & bus.fill_valid;

   wrf_addr_map #(.NREG(NREG), .STRIDE(STRIDE), .NWIN(NWIN)) u_map_rd1 (
      .addr(bus.rd_addr1), .win(cwp_q), .idx(rd1_idx)
   );
   wrf_addr_map #(.NREG(NREG), .STRIDE(STRIDE), .NWIN(NWIN)) u_map_rd2 (
      .addr(bus.rd_addr2), .win(cwp_q), .idx(rd2_idx)
   );
   wrf_addr_map #(.NREG(NREG), .STRIDE(STRIDE), .NWIN(NWIN)) u_map_wr (
      .addr(bus.wr_addr), .win(cwp_q), .idx(wr_idx)
   );
   wrf_addr_map #(.NREG(NREG), .STRIDE(STRIDE), .NWIN(NWIN)) u_map_blk (
      .addr(beat_q), .win(blk_win), .idx(blk_idx)
   );

   assign bus.rd_data1    = phys[rd1_idx];
   assign bus.rd_data2    = phys[rd2_idx];
   assign bus.spill_data  = phys[blk_idx];
   assign bus.spill_valid = spill_valid;
   assign bus.fill_ready  = fill_ready;
   assign bus.busy        = (state != ST_IDLE);
   assign bus.cwp         = cwp_q;
   assign bus.fault       = fault_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PHYS_N; i++) begin
            phys[i] <= '0;
         end
      end else if (bus.wr_en && state == ST_IDLE) begin
         phys[wr_idx] <= bus.wr_data;
      end else if (fill_fire) begin
         phys[blk_idx] <= bus.fill_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cwp_q   <= '0;
         res_q   <= WIN_W'(1);
         spl_q   <= '0;
         beat_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_nx;
         cwp_q   <= cwp_nx;
         res_q   <= res_nx;
         spl_q   <= spl_nx;
         beat_q  <= beat_nx;
         fault_q <= fault_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cwp_nx      = cwp_q;
      res_nx      = res_q;
      spl_nx      = spl_q;
      beat_nx     = beat_q;
      fault_nx    = 1'b0;
      spill_valid = 1'b0;
      fill_ready  = 1'b0;
      case (state)
         ST_IDLE: begin
            beat_nx = '0;
            if (bus.save && !bus.restore) begin
               if (res_q < WIN_W'(NWIN - 1)) begin
                  cwp_nx = cwp_q + WIN_W'(1);
                  res_nx = res_q + WIN_W'(1);
               end else if (spl_q != '1) begin
                  state_nx = ST_SPILL;
               end else begin
                  fault_nx = 1'b1;
               end
            end else if (bus.restore && !bus.save) begin
               if (res_q > WIN_W'(1)) begin
                  cwp_nx = cwp_q - WIN_W'(1);
                  res_nx = res_q - WIN_W'(1);
               end else if (spl_q != '0) begin
                  state_nx = ST_FILL;
               end else begin
                  fault_nx = 1'b1;
               end
            end
         end
         ST_SPILL: begin
            spill_valid = 1'b1;
            if (bus.spill_ready) begin
               beat_nx = beat_q + ADDR_W'(1);
               if (last_beat) begin
                  state_nx = ST_IDLE;
                  cwp_nx   = cwp_q + WIN_W'(1);
                  spl_nx   = spl_q + SPW'(1);
               end
            end
         end
         ST_FILL: begin
            fill_ready = 1'b1;
            if (bus.fill_valid) begin
               beat_nx = beat_q + ADDR_W'(1);
               if (last_beat) begin
                  state_nx = ST_IDLE;
                  cwp_nx   = cwp_q - WIN_W'(1);
                  spl_nx   = spl_q - SPW'(1);
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule
